win_fetch: RTL and testbench

3x3 neighbourhood fetch stage for the median filter datapath. Sits directly downstream of the pixel-address counter: on each `pix_done_sig` pulse it latches the centre pixel's 1-based row/column, reads the nine neighbourhood pixels from the synchronous image ROM and presents them as one packed 72-bit window, with a single-cycle `win_done_sig`, to the median sorter. Image borders are handled by coordinate clamping (edge replication).

---
 rtl/median_pkg.sv | 52 +++++
 rtl/win_addr_gen.sv | 87 ++++++++
 rtl/win_fetch.sv | 200 ++++++++++++++++++++
 tb/tb_win_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// -----------------------------------------------------------------------------
// median_pkg
//   Shared constants and types for the median filter datapath.
//   - PIX_W / ADDR_W : default pixel width and pixel ROM address width
//   - COORD_W        : width of row/column coordinates (1-based)
//   - WIN_TAPS       : number of taps in the 3x3 neighbourhood
//   - win_state_e    : state encoding of the window fetch FSM
//   - tap_dr/tap_dc  : row/column offset of tap k, k = 3*(dr+1)+(dc+1)
//   Offsets are carried as a 2-bit code: 0 -> -1, 1 -> 0, 2 -> +1.
// -----------------------------------------------------------------------------
package median_pkg;

  localparam int PIX_W    = 8;
  localparam int ADDR_W   = 18;
  localparam int COORD_W  = 10;
  localparam int WIN_TAPS = 9;
  localparam int TAP_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } win_state_e;

  localparam logic [1:0] OFS_NEG  = 2'd0;
  localparam logic [1:0] OFS_ZERO = 2'd1;
  localparam logic [1:0] OFS_POS  = 2'd2;

  // Row offset: taps 0..2 are the row above, 3..5 the centre row.
  function automatic logic [1:0] tap_dr(input logic [TAP_W-1:0] k);
    logic [1:0] ofs;
    case (k)
      4'd0, 4'd1, 4'd2: ofs = OFS_NEG;
      4'd3, 4'd4, 4'd5: ofs = OFS_ZERO;
      default:          ofs = OFS_POS;
    endcase
    return ofs;
  endfunction

  // Column offset: first column of each row triple is the left neighbour.
  function automatic logic [1:0] tap_dc(input logic [TAP_W-1:0] k);
    logic [1:0] ofs;
    case (k)
      4'd0, 4'd3, 4'd6: ofs = OFS_NEG;
      4'd1, 4'd4, 4'd7: ofs = OFS_ZERO;
      default:          ofs = OFS_POS;
    endcase
    return ofs;
  endfunction

endpackage

// File: rtl/win_addr_gen.sv
// -----------------------------------------------------------------------------
// win_addr_gen
//   Combinational neighbour address generator. Clamps the centre coordinate
//   into [1,rows] x [1,cols], applies the tap offset, clamps again (edge
//   replication) and forms the linear ROM address (r-1)*cols + (c-1),
//   truncated to ADDR_W.
//   Ports:
//     row, col   : centre coordinate, 1-based
//     rows, cols : image dimensions
//     dr, dc     : offset codes (0 -> -1, 1 -> 0, 2 -> +1)
//     addr       : ROM address of the clamped neighbour
//     oob        : (WIN_ZERO_PAD_EN builds only) unclamped neighbour lies
//                  outside the image
//   Configuration macro: WIN_ZERO_PAD_EN adds the oob output.
//   rows = 0 or cols = 0 is not a meaningful image and is not handled.
// -----------------------------------------------------------------------------
module win_addr_gen #(
  parameter int ADDR_W = 18
) (
  input  logic [9:0]        row,
  input  logic [9:0]        col,
  input  logic [9:0]        rows,
  input  logic [9:0]        cols,
  input  logic [1:0]        dr,
  input  logic [1:0]        dc,
`ifdef WIN_ZERO_PAD_EN
  output logic              oob,
`endif
  output logic [ADDR_W-1:0] addr
);
  import median_pkg::*;

  localparam int XW = ADDR_W - COORD_W;

  logic [9:0]  row_c;
  logic [9:0]  col_c;
  logic [10:0] r_raw;
  logic [10:0] c_raw;
  logic        r_lo;
  logic        r_hi;
  logic        c_lo;
  logic        c_hi;
  logic [9:0]  r_cl;
  logic [9:0]  c_cl;
  logic [9:0]  r_m1;
  logic [9:0]  c_m1;

  always_comb begin
    // Centre clamp: a centre of 0 or beyond the image snaps to the edge.
    if (row == 10'd0)     row_c = 10'd1;
    else if (row > rows)  row_c = rows;
    else                  row_c = row;

    if (col == 10'd0)     col_c = 10'd1;
    else if (col > cols)  col_c = cols;
    else                  col_c = col;

    // Offset code is biased by one, so neighbour = centre + code - 1.
    // The centre is at least 1, so this never wraps below zero.
    r_raw = {1'b0, row_c} + {9'd0, dr} - 11'd1;
    c_raw = {1'b0, col_c} + {9'd0, dc} - 11'd1;

    r_lo = (r_raw == 11'd0);
    r_hi = (r_raw > {1'b0, rows});
    c_lo = (c_raw == 11'd0);
    c_hi = (c_raw > {1'b0, cols});

    if (r_lo)       r_cl = 10'd1;
    else if (r_hi)  r_cl = rows;
    else            r_cl = r_raw[9:0];

    if (c_lo)       c_cl = 10'd1;
    else if (c_hi)  c_cl = cols;
    else            c_cl = c_raw[9:0];

    r_m1 = r_cl - 10'd1;
    c_m1 = c_cl - 10'd1;
  end

  // All operands widened to ADDR_W so the product wraps modulo 2^ADDR_W.
  assign addr = ({{XW{1'b0}}, r_m1} * {{XW{1'b0}}, cols}) + {{XW{1'b0}}, c_m1};

`ifdef WIN_ZERO_PAD_EN
  assign oob = r_lo | r_hi | c_lo | c_hi;
`endif

endmodule

// File: rtl/win_fetch.sv
// -----------------------------------------------------------------------------
// win_fetch
//   3x3 neighbourhood fetch stage. On a pix_done_sig pulse in IDLE the centre
//   coordinate and image size are latched; nine ROM reads are issued (one per
//   cycle, tap order k = 3*(dr+1)+(dc+1)), the returning pixels are shifted
//   into a collection register and the complete window is copied to win_data
//   in one cycle, followed by a one-cycle win_done_sig.
//   Timeline for a pulse in cycle T:
//     T+1..T+9 ISSUE (rom_addr for tap k in T+1+k)
//     T+2..T+10 capture rom_data
//     T+10 DRAIN (win_data loads at end of cycle), T+11 DONE (win_done_sig)
//   Ports:
//     CLK, RSTn        : clock, asynchronous active-low reset
//     pix_done_sig     : centre valid pulse; ignored unless IDLE
//     row_addr_sig     : centre row (1-based)
//     column_addr_sig  : centre column (1-based)
//     rows, cols       : image dimensions
//     rom_addr         : ROM read address; holds last value outside ISSUE
//     rom_data         : ROM read data, one cycle after rom_addr
//     win_data         : packed window, tap k at [PIX_W*k +: PIX_W]
//     win_done_sig     : one-cycle pulse after win_data updates
//     busy             : fetch in progress (T+1..T+11)
//   Configuration macro: WIN_ZERO_PAD_EN - taps whose unclamped coordinate
//   lies outside the image are captured as zero (reads still issue at the
//   clamped address, so timing is identical).
// -----------------------------------------------------------------------------
module win_fetch #(
  parameter int PIX_W  = median_pkg::PIX_W,
  parameter int ADDR_W = median_pkg::ADDR_W
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 pix_done_sig,
  input  logic [9:0]           row_addr_sig,
  input  logic [9:0]           column_addr_sig,
  input  logic [9:0]           rows,
  input  logic [9:0]           cols,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [PIX_W-1:0]     rom_data,
  output logic [9*PIX_W-1:0]   win_data,
  output logic                 win_done_sig,
  output logic                 busy
);
  import median_pkg::*;

  localparam int WIN_W = WIN_TAPS * PIX_W;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(WIN_TAPS - 1);

  // FSM
  win_state_e state_q;
  win_state_e state_d;
  logic       accept;
  logic       issue;
  logic       drain;

  // Latched request
  logic [9:0] row_q, row_d;
  logic [9:0] col_q, col_d;
  logic [9:0] rows_q, rows_d;
  logic [9:0] cols_q, cols_d;

  // Tap counter and capture pipeline
  logic [TAP_W-1:0]  k_q, k_d;
  logic              cap_q, cap_d;
  logic [PIX_W-1:0]  tap_val;
  logic [WIN_W-1:0]  coll_q, coll_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  // Address generator
  logic [1:0]        gen_dr;
  logic [1:0]        gen_dc;
  logic [ADDR_W-1:0] gen_addr;

`ifdef WIN_ZERO_PAD_EN
  logic gen_oob;
  logic oob_q, oob_d;
`endif

  assign gen_dr = tap_dr(k_q);
  assign gen_dc = tap_dc(k_q);

  win_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .row  (row_q),
    .col  (col_q),
    .rows (rows_q),
    .cols (cols_q),
    .dr   (gen_dr),
    .dc   (gen_dc),
`ifdef WIN_ZERO_PAD_EN
    .oob  (gen_oob),
`endif
    .addr (gen_addr)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pix_done_sig) state_d = ST_ISSUE;
      ST_ISSUE: if (k_q == LAST_TAP) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    accept       = (state_q == ST_IDLE) && pix_done_sig;
    issue        = (state_q == ST_ISSUE);
    drain        = (state_q == ST_DRAIN);
    busy         = (state_q != ST_IDLE);
    win_done_sig = (state_q == ST_DONE);
    // Live address during ISSUE so tap k appears in cycle T+1+k; otherwise
    // the last issued address is held.
    rom_addr     = issue ? gen_addr : rom_addr_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    if (accept) begin
      row_d  = row_addr_sig;
      col_d  = column_addr_sig;
      rows_d = rows;
      cols_d = cols;
    end

    k_d        = issue ? (k_q + 4'd1) : '0;
    // ROM data lags the address by one cycle, so capture runs one cycle
    // behind ISSUE and ends in DRAIN.
    cap_d      = issue;
    rom_addr_d = rom_addr;

`ifdef WIN_ZERO_PAD_EN
    oob_d   = issue ? gen_oob : oob_q;
    tap_val = oob_q ? '0 : rom_data;
`else
    tap_val = rom_data;
`endif

    // New taps enter at the top; after nine shifts tap 0 sits in the LSBs.
    coll_d = cap_q ? {tap_val, coll_q[WIN_W-1:PIX_W]} : coll_q;
    // DRAIN carries the final capture, so the whole window loads at once.
    win_d  = drain ? coll_d : win_q;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      row_q      <= '0;
      col_q      <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      k_q        <= '0;
      cap_q      <= 1'b0;
      coll_q     <= '0;
      win_q      <= '0;
      rom_addr_q <= '0;
`ifdef WIN_ZERO_PAD_EN
      oob_q      <= 1'b0;
`endif
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      k_q        <= k_d;
      cap_q      <= cap_d;
      coll_q     <= coll_d;
      win_q      <= win_d;
      rom_addr_q <= rom_addr_d;
`ifdef WIN_ZERO_PAD_EN
      oob_q      <= oob_d;
`endif
    end
  end

  assign win_data = win_q;

endmodule

// File: tb/tb_win_fetch.sv
// -----------------------------------------------------------------------------
// tb_win_fetch
//   Scoreboard bench for win_fetch. Drivers push expected windows, done
//   cycles, per-tap ROM addresses and busy windows; a negedge monitor pops and
//   compares whenever the DUT presents them. Expected values come from a
//   coordinate-level reference model over a behavioural ROM array.
// -----------------------------------------------------------------------------
module tb_win_fetch;

  localparam int PW    = 8;
  localparam int AW    = 18;
  localparam int WW    = 9 * PW;
  localparam int ROM_N = 1024;

  logic          clk;
  logic          rst_n;
  logic          pix_done_sig;
  logic [9:0]    row_addr_sig;
  logic [9:0]    column_addr_sig;
  logic [9:0]    rows;
  logic [9:0]    cols;
  logic [AW-1:0] rom_addr;
  logic [PW-1:0] rom_data;
  logic [WW-1:0] win_data;
  logic          win_done_sig;
  logic          busy;

  win_fetch #(.PIX_W(PW), .ADDR_W(AW)) dut (
    .CLK             (clk),
    .RSTn            (rst_n),
    .pix_done_sig    (pix_done_sig),
    .row_addr_sig    (row_addr_sig),
    .column_addr_sig (column_addr_sig),
    .rows            (rows),
    .cols            (cols),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .win_data        (win_data),
    .win_done_sig    (win_done_sig),
    .busy            (busy)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset / ROM model
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [PW-1:0] rom [ROM_N];
  always @(posedge clk) rom_data <= rom[rom_addr[9:0]];

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [WW-1:0] exp_q[$];
  int            exp_t_q[$];
  logic [AW-1:0] addr_q[$];
  int            addr_t_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int next_free = 0;
  int busy_lo = 0;
  int busy_hi = -1;
  logic [WW-1:0] last_win = '0;
  logic          stable_ok = 1'b1;

  task automatic chk(input string name, input logic [WW-1:0] got, input logic [WW-1:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int ref_addr(input int row, input int col, input int nr, input int nc, input int k);
    int rc, cc, r, c;
    rc = clampi(row, 1, nr);
    cc = clampi(col, 1, nc);
    r  = clampi(rc + k / 3 - 1, 1, nr);
    c  = clampi(cc + k % 3 - 1, 1, nc);
    return ((r - 1) * nc + (c - 1)) % (1 << AW);
  endfunction

  function automatic logic [WW-1:0] ref_win(input int row, input int col, input int nr, input int nc);
    logic [WW-1:0] w;
    int rc, cc, ra, ca;
    w  = '0;
    rc = clampi(row, 1, nr);
    cc = clampi(col, 1, nc);
    for (int k = 0; k < 9; k++) begin
      ra = rc + k / 3 - 1;
      ca = cc + k % 3 - 1;
      w[PW*k +: PW] = rom[ref_addr(row, col, nr, nc, k) % ROM_N];
`ifdef WIN_ZERO_PAD_EN
      if (ra < 1 || ra > nr || ca < 1 || ca > nc) w[PW*k +: PW] = '0;
`endif
    end
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge)
  // ---------------------------------------------------------------------------
  task automatic drive_pulse(input int r, input int c, input int nr, input int nc);
    int t;
    t = cyc;
    pix_done_sig    = 1'b1;
    row_addr_sig    = 10'(r);
    column_addr_sig = 10'(c);
    rows            = 10'(nr);
    cols            = 10'(nc);
    if (t >= next_free) begin
      next_free = t + 12;
      busy_lo   = t + 1;
      busy_hi   = t + 11;
      exp_q.push_back(ref_win(r, c, nr, nc));
      exp_t_q.push_back(t + 11);
      for (int k = 0; k < 9; k++) begin
        addr_q.push_back(AW'(ref_addr(r, c, nr, nc, k)));
        addr_t_q.push_back(t + 1 + k);
      end
    end
    @(negedge clk);
    pix_done_sig = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic flush_sb();
    exp_q.delete();
    exp_t_q.delete();
    addr_q.delete();
    addr_t_q.delete();
    next_free = 0;
    busy_hi   = -1;
    last_win  = '0;
    stable_ok = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", WW'(busy), WW'(cyc >= busy_lo && cyc <= busy_hi));

      while (addr_q.size() != 0 && addr_t_q[0] < cyc) begin
        n_checks++;
        $display("FAIL rom_addr_missed: got no check, required %h at cycle %0d", addr_q[0], addr_t_q[0]);
        void'(addr_q.pop_front());
        void'(addr_t_q.pop_front());
      end
      if (addr_q.size() != 0 && addr_t_q[0] == cyc) begin
        chk("rom_addr", WW'(rom_addr), WW'(addr_q.pop_front()));
        void'(addr_t_q.pop_front());
      end

      if (win_done_sig) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_done: got win_done_sig=1 required 0 (cycle %0d)", cyc);
        end else begin
          chk("win_data", win_data, exp_q.pop_front());
          chk("done_cycle", WW'(cyc), WW'(exp_t_q.pop_front()));
          chk("win_stable", WW'(stable_ok), WW'(1));
        end
        last_win  = win_data;
        stable_ok = 1'b1;
      end else if (win_data !== last_win) begin
        stable_ok = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t0;
    rst_n           = 1'b0;
    pix_done_sig    = 1'b0;
    row_addr_sig    = '0;
    column_addr_sig = '0;
    rows            = 10'd4;
    cols            = 10'd4;
    for (int i = 0; i < ROM_N; i++) rom[i] = PW'(i);

    repeat (3) @(negedge clk);
    chk("reset_rom_addr", WW'(rom_addr), '0);
    chk("reset_win_data", win_data, '0);
    chk("reset_done", WW'(win_done_sig), '0);
    chk("reset_busy", WW'(busy), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed windows on a 4x4 image with ROM[i] = i.
    drive_pulse(2, 2, 4, 4); wait_drain();
    drive_pulse(1, 1, 4, 4); wait_drain();
    drive_pulse(4, 4, 4, 4); wait_drain();
    drive_pulse(0, 0, 4, 4); wait_drain();
    drive_pulse(7, 9, 4, 4); wait_drain();
    drive_pulse(1, 3, 1, 5); wait_drain();
    drive_pulse(2, 1, 3, 1); wait_drain();

    // Pulses at T, T+5 (ignored), T+12.
    t0 = cyc;
    drive_pulse(2, 2, 4, 4);
    wait_to(t0 + 5);
    drive_pulse(3, 1, 4, 4);
    wait_to(t0 + 12);
    drive_pulse(4, 4, 4, 4);
    wait_drain();

    // Asynchronous reset mid-fetch.
    t0 = cyc;
    drive_pulse(2, 3, 4, 4);
    wait_to(t0 + 6);
    #2 rst_n = 1'b0;
    flush_sb();
    #1;
    chk("midrst_rom_addr", WW'(rom_addr), '0);
    chk("midrst_win_data", win_data, '0);
    chk("midrst_done", WW'(win_done_sig), '0);
    chk("midrst_busy", WW'(busy), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_pulse(3, 3, 4, 4); wait_drain();

    // Random images, coordinates and pulse spacing.
    for (int i = 0; i < ROM_N; i++) rom[i] = PW'($urandom);
    for (int n = 0; n < 40; n++) begin
      int nr, nc;
      nr = $urandom_range(1, 30);
      nc = $urandom_range(1, 30);
      drive_pulse($urandom_range(0, nr + 1), $urandom_range(0, nc + 1), nr, nc);
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end
    wait_drain();

    while (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL window_timeout: got no win_done_sig, required window %h", exp_q.pop_front());
    end
    while (addr_q.size() != 0) begin
      n_checks++;
      $display("FAIL rom_addr_timeout: got no check, required %h", addr_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
